ifu_fetch: RTL and testbench

Instruction fetch unit that produces the 32-bit instruction stream consumed by the decode stage (io_inst / PC pair).
- Issues one outstanding word read to instruction memory at a time.
- Holds the returned instruction behind a valid/ready handshake toward decode.
- Accepts PC redirects from the branch/jump resolution logic.
- Stops fetching after an ebreak (32'h00100073) is consumed.

---
 rtl/ifu_fetch.sv | 115 +++++++++++
 tb/tb_ifu_fetch.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem read, valid/ready hold toward decode,
// PC redirects with in-flight response squashing, and halt after a consumed ebreak.
module ifu_fetch #(
  parameter int unsigned      XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000000080000000
) (
  input  logic            clock,
  input  logic            reset,
  output logic            io_imem_req_valid,
  input  logic            io_imem_req_ready,
  output logic [XLEN-1:0] io_imem_req_addr,
  input  logic            io_imem_resp_valid,
  input  logic [31:0]     io_imem_resp_data,
  input  logic            io_redirect_valid,
  input  logic [XLEN-1:0] io_redirect_pc,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [31:0]     io_out_inst,
  output logic [XLEN-1:0] io_out_pc,
  output logic            io_halted
);

  localparam logic [31:0] EBREAK = 32'h00100073;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StHalt} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_r_q, pc_r_d;
  logic [31:0]     inst_q, inst_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_lsb;

  assign redirect_target     = {io_redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^io_redirect_pc[1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      pc_r_q  <= '0;
      inst_q  <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc_r_q  <= pc_r_d;
      inst_q  <= inst_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc_r_d  = pc_r_q;
    inst_d  = inst_q;
    kill_d  = kill_q;
    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (io_redirect_valid) pc_d = redirect_target;
      end
      StReq: begin
        if (io_redirect_valid) pc_d = redirect_target;
        // A redirect coinciding with acceptance leaves a stale-address read in flight.
        if (io_imem_req_ready) begin
          state_d = StWait;
          kill_d  = io_redirect_valid;
        end
      end
      StWait: begin
        if (io_redirect_valid) begin
          pc_d   = redirect_target;
          kill_d = 1'b1;
        end
        if (io_imem_resp_valid) begin
          if (kill_q || io_redirect_valid) begin
            kill_d  = 1'b0;
            state_d = StReq;
          end else begin
            inst_d  = io_imem_resp_data;
            pc_r_d  = pc_q;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        // Redirect wins over both the sequential pc+4 and an ebreak halt.
        if (io_redirect_valid) begin
          pc_d    = redirect_target;
          state_d = StReq;
        end else if (io_out_ready) begin
          if (inst_q == EBREAK) begin
            state_d = StHalt;
          end else begin
            pc_d    = pc_q + XLEN'(4);
            state_d = StReq;
          end
        end
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  assign io_imem_req_valid = (state_q == StReq);
  assign io_imem_req_addr  = {pc_q[XLEN-1:2], 2'b00};
  assign io_out_valid      = (state_q == StHold);
  assign io_out_inst       = inst_q;
  assign io_out_pc         = pc_r_q;
  assign io_halted         = (state_q == StHalt);

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: queue-backed memory model, scoreboard on decode handshakes,
// a vector table for sequential fetches and hand sequences for redirect/halt/reset.
module tb_ifu_fetch;

  localparam int unsigned XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h0000000080000000;
  localparam logic [31:0] EBREAK   = 32'h00100073;

  logic        clock, reset;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        halted;

  ifu_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_imem_req_valid  (req_valid),
    .io_imem_req_ready  (req_ready),
    .io_imem_req_addr   (req_addr),
    .io_imem_resp_valid (resp_valid),
    .io_imem_resp_data  (resp_data),
    .io_redirect_valid  (redirect_valid),
    .io_redirect_pc     (redirect_pc),
    .io_out_valid       (out_valid),
    .io_out_ready       (out_ready),
    .io_out_inst        (out_inst),
    .io_out_pc          (out_pc),
    .io_halted          (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    int unsigned lat;
    int unsigned stall;
    logic [63:0] pc;
  } vec_t;

  exp_t        sb_q[$];
  logic [31:0] mem_q[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned mem_lat = 1;
  int unsigned mem_cnt = 0;
  logic [31:0] mem_data;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {63'b0, act}, {63'b0, exp});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    sb_q.push_back(e);
    mem_q.push_back(inst);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL wait_out_valid: got timeout want out_valid");
    end
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Memory: accept when req_valid && req_ready at the edge, reply mem_lat edges later.
  initial begin
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      @(negedge clock);
      resp_valid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          resp_valid = 1'b1;
          resp_data  = mem_data;
        end
      end
      if (req_valid && req_ready && !reset) begin
        mem_cnt  = mem_lat;
        mem_data = (mem_q.size() != 0) ? mem_q.pop_front() : 32'h00000013;
      end
    end
  end

  // Scoreboard: every decode handshake must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got pc=%h inst=%h want none", out_pc, out_inst);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_out_pc", out_pc, mon_e.pc);
          chk("sb_out_inst", {32'b0, out_inst}, {32'b0, mon_e.inst});
        end
      end
    end
  end

  vec_t vecs[4];

  initial begin
    int n;
    vecs[0] = '{inst: 32'h00000013, lat: 1, stall: 10, pc: 64'h80000004};
    vecs[1] = '{inst: 32'h00a00093, lat: 2, stall: 0,  pc: 64'h80000008};
    vecs[2] = '{inst: 32'h00b00113, lat: 3, stall: 2,  pc: 64'h8000000C};
    vecs[3] = '{inst: 32'h002081b3, lat: 1, stall: 0,  pc: 64'h80000010};

    reset          = 1'b1;
    req_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    // Reset state and first-fetch timing.
    repeat (2) @(negedge clock);
    chk1("rst_req_valid", req_valid, 1'b0);
    chk("rst_req_addr", req_addr, RESET_PC);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_inst", {32'b0, out_inst}, 64'h0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk1("rst_halted", halted, 1'b0);
    push_exp(RESET_PC, 32'h00500093);
    reset = 1'b0;
    step();
    chk1("c1_req_valid", req_valid, 1'b1);
    chk("c1_req_addr", req_addr, RESET_PC);
    step();
    chk1("c2_out_valid", out_valid, 1'b0);
    step();
    chk1("c3_out_valid", out_valid, 1'b1);
    chk("c3_out_pc", out_pc, RESET_PC);
    chk("c3_out_inst", {32'b0, out_inst}, 64'h00500093);
    out_ready = 1'b1;
    step();
    chk("next_req_addr", req_addr, 64'h80000004);

    // Sequential fetches with varying latency and decode backpressure.
    for (int i = 0; i < 4; i++) begin
      mem_lat = vecs[i].lat;
      push_exp(vecs[i].pc, vecs[i].inst);
      out_ready = (vecs[i].stall == 0);
      wait_out(n);
      chk("latency", 64'(n), 64'(vecs[i].lat + 1));
      for (int c = 0; c < int'(vecs[i].stall); c++) begin
        chk1("stall_out_valid", out_valid, 1'b1);
        chk1("stall_no_req", req_valid, 1'b0);
        chk("stall_out_inst", {32'b0, out_inst}, {32'b0, vecs[i].inst});
        chk("stall_out_pc", out_pc, vecs[i].pc);
        step();
      end
      out_ready = 1'b1;
      step();
      chk1("vec_next_req_valid", req_valid, 1'b1);
      chk("vec_next_req_addr", req_addr, vecs[i].pc + 64'd4);
    end

    // Redirect in WAIT squashes the in-flight response.
    mem_lat = 2;
    mem_q.push_back(32'hDEADBEEF);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h80001002;
    step();
    redirect_valid = 1'b0;
    chk1("rdw_out_valid_a", out_valid, 1'b0);
    mem_lat = 1;
    push_exp(64'h80001000, 32'h00100513);
    step();
    chk1("rdw_out_valid_b", out_valid, 1'b0);
    chk1("rdw_req_valid", req_valid, 1'b1);
    chk("rdw_req_addr", req_addr, 64'h80001000);
    drain();

    // Redirect in HOLD together with out_ready: consumed, but pc takes the target.
    out_ready = 1'b0;
    push_exp(64'h80001004, 32'h00200593);
    wait_out(n);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h80000100;
    push_exp(64'h80000100, 32'h00300613);
    step();
    redirect_valid = 1'b0;
    chk1("rdh_req_valid", req_valid, 1'b1);
    chk("rdh_req_addr", req_addr, 64'h80000100);
    drain();

    // Ebreak halts; redirect afterwards is ignored.
    push_exp(64'h80000104, EBREAK);
    drain();
    chk1("halt_halted", halted, 1'b1);
    chk1("halt_req_valid", req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h80002000;
    repeat (2) step();
    redirect_valid = 1'b0;
    step();
    chk1("halt_sticky", halted, 1'b1);
    chk1("halt_no_req", req_valid, 1'b0);
    chk1("halt_no_out", out_valid, 1'b0);

    // Asynchronous reset out of HALT.
    #2 reset = 1'b1;
    #1;
    chk1("areset_halted", halted, 1'b0);
    chk("areset_req_addr", req_addr, RESET_PC);
    @(negedge clock);
    reset = 1'b0;

    // Redirect while REQ stalls, low bits ignored, then pc+4 wraps to zero.
    req_ready = 1'b0;
    step();
    chk1("wr_req_valid", req_valid, 1'b1);
    chk("wr_req_addr0", req_addr, RESET_PC);
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFFFFFFFFFFFFFE;
    step();
    redirect_valid = 1'b0;
    chk1("wr_req_valid_b", req_valid, 1'b1);
    chk("wr_req_addr_top", req_addr, 64'hFFFFFFFFFFFFFFFC);
    push_exp(64'hFFFFFFFFFFFFFFFC, 32'h00400693);
    req_ready = 1'b1;
    drain();
    chk1("wr_wrap_valid", req_valid, 1'b1);
    chk("wr_wrap_addr", req_addr, 64'h0);
    push_exp(64'h0, 32'h00500713);
    drain();
    chk("wr_after_wrap", req_addr, 64'h4);

    // Reset while in WAIT; memory answers during reset and must be ignored.
    mem_lat = 2;
    mem_q.push_back(32'hCAFEF00D);
    step();
    #2 reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk1("rstw_out_valid", out_valid, 1'b0);
      chk1("rstw_req_valid", req_valid, 1'b0);
    end
    mem_lat = 1;
    push_exp(RESET_PC, 32'h00600793);
    reset = 1'b0;
    step();
    chk1("rstw_restart_valid", req_valid, 1'b1);
    chk("rstw_restart_addr", req_addr, RESET_PC);
    drain();
    chk("rstw_next_addr", req_addr, RESET_PC + 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
